// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel/line counters plus sync, active-area and
// frame markers delayed by PIPE_DELAY pixel ticks to line up with downstream pixel logic.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 1280,
  parameter int H_FP       = 72,
  parameter int H_SYNC     = 128,
  parameter int H_BP       = 200,
  parameter int V_ACTIVE   = 800,
  parameter int V_FP       = 3,
  parameter int V_SYNC     = 6,
  parameter int V_BP       = 22,
  parameter int HSYNC_POL  = 0,
  parameter int VSYNC_POL  = 1,
  parameter int X_W        = 11,
  parameter int Y_W        = 10,
  parameter int PIPE_DELAY = 1,
  parameter int FRAME_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en,
  output logic [X_W-1:0]     curr_x,
  output logic [Y_W-1:0]     curr_y,
  output logic               hsync,
  output logic               vsync,
  output logic               active_area,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [X_W-1:0] X_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] X_ACT    = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] HS_FIRST = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HS_LAST  = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [Y_W-1:0] Y_LAST   = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] Y_ACT    = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] VS_FIRST = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VS_LAST  = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic HS_ON = (HSYNC_POL != 0);
  localparam logic VS_ON = (VSYNC_POL != 0);

  if ((H_TOTAL - 1) >= (2 ** X_W)) begin : g_chk_x
    $error("vga_timing_gen: H_TOTAL-1 does not fit in X_W bits");
  end
  if ((V_TOTAL - 1) >= (2 ** Y_W)) begin : g_chk_y
    $error("vga_timing_gen: V_TOTAL-1 does not fit in Y_W bits");
  end
  if ((H_SYNC == 0) || (V_SYNC == 0)) begin : g_chk_sync
    $error("vga_timing_gen: H_SYNC and V_SYNC must be non-zero");
  end
  if ((PIPE_DELAY < 1) || (PIPE_DELAY > 8)) begin : g_chk_pipe
    $error("vga_timing_gen: PIPE_DELAY must be within 1..8");
  end

  logic [X_W-1:0]        x_q, x_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic [FRAME_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic [PIPE_DELAY-1:0] act_pipe_q, act_pipe_d;
  logic [PIPE_DELAY-1:0] hs_pipe_q, hs_pipe_d;
  logic [PIPE_DELAY-1:0] vs_pipe_q, vs_pipe_d;
  logic [PIPE_DELAY-1:0] ls_pipe_q, ls_pipe_d;
  logic [PIPE_DELAY-1:0] fs_pipe_q, fs_pipe_d;

  logic dec_act_s, dec_hs_s, dec_vs_s, dec_ls_s, dec_fs_s;

  // Decode of the undelayed position; sync levels already carry their polarity.
  always_comb begin
    dec_act_s = (x_q < X_ACT) && (y_q < Y_ACT);
    dec_hs_s  = ((x_q >= HS_FIRST) && (x_q <= HS_LAST)) ? HS_ON : ~HS_ON;
    dec_vs_s  = ((y_q >= VS_FIRST) && (y_q <= VS_LAST)) ? VS_ON : ~VS_ON;
    dec_ls_s  = (x_q == {X_W{1'b0}});
    dec_fs_s  = (x_q == {X_W{1'b0}}) && (y_q == {Y_W{1'b0}});
  end

  // Next-state: raster counters, delay pipeline and frame counter.
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    frame_cnt_d = frame_cnt_q;
    act_pipe_d  = act_pipe_q;
    hs_pipe_d   = hs_pipe_q;
    vs_pipe_d   = vs_pipe_q;
    ls_pipe_d   = ls_pipe_q;
    fs_pipe_d   = fs_pipe_q;
    if (pix_en) begin
      if (x_q == X_LAST) begin
        x_d = {X_W{1'b0}};
        if (y_q == Y_LAST) begin
          y_d = {Y_W{1'b0}};
        end else begin
          y_d = y_q + Y_W'(1);
        end
      end else begin
        x_d = x_q + X_W'(1);
      end
      act_pipe_d[0] = dec_act_s;
      hs_pipe_d[0]  = dec_hs_s;
      vs_pipe_d[0]  = dec_vs_s;
      ls_pipe_d[0]  = dec_ls_s;
      fs_pipe_d[0]  = dec_fs_s;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        act_pipe_d[i] = act_pipe_q[i-1];
        hs_pipe_d[i]  = hs_pipe_q[i-1];
        vs_pipe_d[i]  = vs_pipe_q[i-1];
        ls_pipe_d[i]  = ls_pipe_q[i-1];
        fs_pipe_d[i]  = fs_pipe_q[i-1];
      end
      if (fs_pipe_d[PIPE_DELAY-1]) begin
        frame_cnt_d = frame_cnt_q + FRAME_W'(1);
      end else begin
        frame_cnt_d = frame_cnt_q;
      end
    end else begin
      // The last pulse stage is never shifted onward, so clearing it on idle
      // cycles keeps line_start/frame_start exactly one clk wide.
      ls_pipe_d[PIPE_DELAY-1] = 1'b0;
      fs_pipe_d[PIPE_DELAY-1] = 1'b0;
    end
  end

  // State registers; reset fills the pipeline with inactive levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q         <= {X_W{1'b0}};
      y_q         <= {Y_W{1'b0}};
      frame_cnt_q <= {FRAME_W{1'b0}};
      act_pipe_q  <= {PIPE_DELAY{1'b0}};
      hs_pipe_q   <= {PIPE_DELAY{~HS_ON}};
      vs_pipe_q   <= {PIPE_DELAY{~VS_ON}};
      ls_pipe_q   <= {PIPE_DELAY{1'b0}};
      fs_pipe_q   <= {PIPE_DELAY{1'b0}};
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      frame_cnt_q <= frame_cnt_d;
      act_pipe_q  <= act_pipe_d;
      hs_pipe_q   <= hs_pipe_d;
      vs_pipe_q   <= vs_pipe_d;
      ls_pipe_q   <= ls_pipe_d;
      fs_pipe_q   <= fs_pipe_d;
    end
  end

  assign curr_x      = x_q;
  assign curr_y      = y_q;
  assign hsync       = hs_pipe_q[PIPE_DELAY-1];
  assign vsync       = vs_pipe_q[PIPE_DELAY-1];
  assign active_area = act_pipe_q[PIPE_DELAY-1];
  assign line_start  = ls_pipe_q[PIPE_DELAY-1];
  assign frame_start = fs_pipe_q[PIPE_DELAY-1];
  assign frame_cnt   = frame_cnt_q;

endmodule
